// File: rtl/pc_ctrl.sv
// Fetch-stage PC unit: next-PC selection, fetch address check,
// and saturating redirect/stall counters.
module pc_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IMEM_SIZE  = 32'h0000_4000,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       PCSel,
    input  logic             branch,
    input  logic [25:0]      imm,
    input  logic [15:0]      offset,
    input  logic [31:0]      ra,
    input  logic [31:0]      D_pc,
    input  logic             req_exc,
    input  logic             req_eret,
    input  logic [31:0]      epc,
    input  logic             cnt_clr,
    output logic [31:0]      F_pc,
    output logic             F_adel,
    output logic [CNT_W-1:0] cnt_redirect,
    output logic [CNT_W-1:0] cnt_stall
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [32:0]      LO_BND  = {1'b0, IMEM_BASE};
    localparam logic [32:0]      HI_BND  = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};

    logic [31:0] pc_seq;
    logic [31:0] pc_br;
    logic [31:0] pc_j;
    logic [31:0] pc_next;

    logic sel_exc;
    logic sel_eret;
    logic sel_hold;
    logic sel_jr;
    logic sel_br;
    logic sel_j;
    logic sel_redir;

    assign pc_seq = F_pc + 32'd4;
    assign pc_br  = D_pc + 32'd4 + {{14{offset[15]}}, offset, 2'b00};
    assign pc_j   = {D_pc[31:28], imm, 2'b00};

    // Mutually exclusive selects so the mux below can be a parallel case.
    assign sel_exc   = req_exc;
    assign sel_eret  = req_eret & ~req_exc;
    assign sel_hold  = stall & ~req_exc & ~req_eret;
    assign sel_jr    = ~stall & ~req_exc & ~req_eret & (PCSel == 2'd3);
    assign sel_br    = ~stall & ~req_exc & ~req_eret & (PCSel == 2'd1) & branch;
    assign sel_j     = ~stall & ~req_exc & ~req_eret & (PCSel == 2'd2);
    assign sel_redir = sel_jr | sel_br | sel_j;

    always_comb begin
        pc_next = pc_seq;
        unique case (1'b1)
            sel_exc:  pc_next = HANDLER_PC;
            sel_eret: pc_next = epc;
            sel_hold: pc_next = F_pc;
            sel_jr:   pc_next = ra;
            sel_br:   pc_next = pc_br;
            sel_j:    pc_next = pc_j;
            default:  pc_next = pc_seq;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            F_pc <= RESET_PC;
        end else begin
            F_pc <= pc_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_redirect <= '0;
            cnt_stall    <= '0;
        end else if (cnt_clr) begin
            cnt_redirect <= '0;
            cnt_stall    <= '0;
        end else begin
            if (sel_redir && cnt_redirect != CNT_MAX) begin
                cnt_redirect <= cnt_redirect + CNT_ONE;
            end
            if (sel_hold && cnt_stall != CNT_MAX) begin
                cnt_stall <= cnt_stall + CNT_ONE;
            end
        end
    end

    // 33-bit compare keeps the upper bound free of wrap.
    assign F_adel = (F_pc[1:0] != 2'b00)
                  || ({1'b0, F_pc} < LO_BND)
                  || ({1'b0, F_pc} >= HI_BND);

endmodule

// File: tb/tb_pc_ctrl.sv
// Randomised + directed bench for pc_ctrl against a behavioural model.
// A second instance with 2-bit counters exercises saturation.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  pcsel;
    logic        branch;
    logic [25:0] imm;
    logic [15:0] offset;
    logic [31:0] ra;
    logic [31:0] d_pc;
    logic        req_exc;
    logic        req_eret;
    logic [31:0] epc;
    logic        cnt_clr;

    logic [31:0] f_pc;
    logic        f_adel;
    logic [31:0] cnt_red;
    logic [31:0] cnt_stl;
    logic [31:0] f_pc2;
    logic        f_adel2;
    logic [1:0]  cnt_red2;
    logic [1:0]  cnt_stl2;

    int n_tests = 0;
    int n_fail  = 0;

    longint unsigned m_pc;
    longint unsigned m_red;
    longint unsigned m_stl;
    longint unsigned m_red2;
    longint unsigned m_stl2;

    always #5 clk = ~clk;

    pc_ctrl dut (
        .clk(clk), .reset(reset), .stall(stall), .PCSel(pcsel),
        .branch(branch), .imm(imm), .offset(offset), .ra(ra),
        .D_pc(d_pc), .req_exc(req_exc), .req_eret(req_eret),
        .epc(epc), .cnt_clr(cnt_clr), .F_pc(f_pc), .F_adel(f_adel),
        .cnt_redirect(cnt_red), .cnt_stall(cnt_stl)
    );

    pc_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .PCSel(pcsel),
        .branch(branch), .imm(imm), .offset(offset), .ra(ra),
        .D_pc(d_pc), .req_exc(req_exc), .req_eret(req_eret),
        .epc(epc), .cnt_clr(cnt_clr), .F_pc(f_pc2), .F_adel(f_adel2),
        .cnt_redirect(cnt_red2), .cnt_stall(cnt_stl2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_adel(input longint unsigned pc);
        return (pc % 4 != 0) || (pc < 64'h3000) || (pc >= 64'h3000 + 64'h4000);
    endfunction

    // src: 0 = flush, 1 = held by stall, 2 = taken redirect, 3 = sequential
    function automatic longint unsigned model_next(output int src);
        int so;
        if (req_exc) begin
            src = 0;
            return 64'h4180;
        end
        if (req_eret) begin
            src = 0;
            return 64'(epc);
        end
        if (stall) begin
            src = 1;
            return m_pc;
        end
        src = 2;
        if (pcsel == 2'd3) return 64'(ra);
        if (pcsel == 2'd1 && branch) begin
            so = int'($signed(offset));
            return (64'(d_pc) + 4 + longint'(so) * 4) % 64'h1_0000_0000;
        end
        if (pcsel == 2'd2)
            return (64'(d_pc) & 64'hF000_0000) + 64'(imm) * 4;
        src = 3;
        return (m_pc + 4) % 64'h1_0000_0000;
    endfunction

    function automatic longint unsigned sat_inc(input longint unsigned v,
                                                input longint unsigned mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_pc   = 64'h3000;
        m_red  = 0;
        m_stl  = 0;
        m_red2 = 0;
        m_stl2 = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    f_pc,  32'(m_pc));
        chk({tag, ".adel"},  32'(f_adel), 32'(model_adel(m_pc)));
        chk({tag, ".red"},   cnt_red, 32'(m_red));
        chk({tag, ".stl"},   cnt_stl, 32'(m_stl));
        chk({tag, ".pc2"},   f_pc2, 32'(m_pc));
        chk({tag, ".red2"},  32'(cnt_red2), 32'(m_red2));
        chk({tag, ".stl2"},  32'(cnt_stl2), 32'(m_stl2));
    endtask

    task automatic tick(input string tag);
        int src;
        longint unsigned nxt;
        nxt = model_next(src);
        @(posedge clk);
        #1;
        m_pc = nxt;
        if (cnt_clr) begin
            m_red = 0; m_stl = 0; m_red2 = 0; m_stl2 = 0;
        end else if (src == 2) begin
            m_red  = sat_inc(m_red, 64'hFFFF_FFFF);
            m_red2 = sat_inc(m_red2, 3);
        end else if (src == 1) begin
            m_stl  = sat_inc(m_stl, 64'hFFFF_FFFF);
            m_stl2 = sat_inc(m_stl2, 3);
        end
        check_all(tag);
    endtask

    task automatic idle_inputs();
        stall = 0; pcsel = 0; branch = 0; imm = 0; offset = 0;
        ra = 0; d_pc = 0; req_exc = 0; req_eret = 0; epc = 0; cnt_clr = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.pc", f_pc, 32'h3000);
        chk("rst.adel", 32'(f_adel), 32'd0);
        check_all("rst");
        reset = 1'b0;

        tick("free1"); chk("free1.c", f_pc, 32'h3004);
        tick("free2"); chk("free2.c", f_pc, 32'h3008);
        tick("free3"); chk("free3.c", f_pc, 32'h300C);

        d_pc = 32'h3010; pcsel = 2'd1; branch = 1; offset = 16'hFFFC;
        tick("br_t");
        chk("br_t.c", f_pc, 32'h3004);
        chk("br_t.red", cnt_red, 32'd1);
        branch = 0;
        tick("br_nt");
        chk("br_nt.c", f_pc, 32'h3008);
        chk("br_nt.red", cnt_red, 32'd1);

        pcsel = 0; cnt_clr = 1;
        tick("clr");
        cnt_clr = 0;
        stall = 1; pcsel = 2'd3; ra = 32'h3400;
        tick("jr_s1");
        tick("jr_s2");
        chk("jr_s.pc", f_pc, 32'h300C);
        chk("jr_s.stl", cnt_stl, 32'd2);
        stall = 0;
        tick("jr_go");
        chk("jr_go.pc", f_pc, 32'h3400);
        chk("jr_go.red", cnt_red, 32'd1);

        stall = 1; req_exc = 1; pcsel = 2'd2; imm = 26'h123;
        tick("exc");
        chk("exc.pc", f_pc, 32'h4180);
        chk("exc.red", cnt_red, 32'd1);
        chk("exc.stl", cnt_stl, 32'd2);
        req_eret = 1; epc = 32'h3800;
        tick("exc_eret");
        chk("exc_eret.pc", f_pc, 32'h4180);

        stall = 0; req_exc = 0; pcsel = 0;
        epc = 32'h3002;
        tick("eret_mis");
        chk("eret_mis.pc", f_pc, 32'h3002);
        chk("eret_mis.adel", 32'(f_adel), 32'd1);
        epc = 32'h7000;
        tick("eret_hi");
        chk("eret_hi.adel", 32'(f_adel), 32'd1);
        epc = 32'h6FFC;
        tick("eret_top");
        chk("eret_top.adel", 32'(f_adel), 32'd0);
        req_eret = 0;

        cnt_clr = 1;
        tick("sat_clr");
        cnt_clr = 0; stall = 1;
        repeat (5) tick("sat");
        chk("sat.stl2", 32'(cnt_stl2), 32'd3);
        chk("sat.stl", cnt_stl, 32'd5);
        cnt_clr = 1;
        tick("sat_clr2");
        chk("sat_clr2.stl2", 32'(cnt_stl2), 32'd0);
        cnt_clr = 0; stall = 0;

        // async reset between edges
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst.pc", f_pc, 32'h3000);
        chk("arst.stl", cnt_stl, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            stall    = ($urandom_range(0, 3) == 0);
            req_exc  = ($urandom_range(0, 19) == 0);
            req_eret = ($urandom_range(0, 19) == 0);
            cnt_clr  = ($urandom_range(0, 49) == 0);
            pcsel    = 2'($urandom_range(0, 3));
            branch   = 1'($urandom_range(0, 1));
            imm      = 26'($urandom);
            offset   = 16'($urandom);
            d_pc     = ($urandom_range(0, 7) == 0) ? $urandom
                                                   : 32'h3000 + ($urandom_range(0, 4095) << 2);
            ra       = ($urandom_range(0, 3) == 0) ? $urandom
                                                   : 32'h3000 + ($urandom_range(0, 4095) << 2);
            epc      = ($urandom_range(0, 3) == 0) ? $urandom
                                                   : 32'h3000 + ($urandom_range(0, 4095) << 2);
            tick("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
